// File: rtl/pyr_expand.sv
// Pyramid EXPAND stage: 2x horizontal and 2x vertical upsampling through ping-pong row banks.
// Define PYR_EXPAND_SMOOTH_EN to interpolate odd output pixels instead of replicating them.
module pyr_expand #(
  parameter int unsigned PIXELS_PER_BEAT = 16,
  parameter int unsigned INPUT_WIDTH     = 8,
  parameter int unsigned IMAGE_DIM       = 512,
  parameter int unsigned DATA_WIDTH      = INPUT_WIDTH * PIXELS_PER_BEAT
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] in_frame,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_frame,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_eol,
  output logic                  out_eof
);

  localparam int unsigned P         = PIXELS_PER_BEAT;
  localparam int unsigned W         = INPUT_WIDTH;
  localparam int unsigned HALF      = P / 2;
  localparam int unsigned HALF_DW   = DATA_WIDTH / 2;
  localparam int unsigned IN_BEATS  = IMAGE_DIM / (2 * P);
  localparam int unsigned OUT_BEATS = 2 * IN_BEATS;
  localparam int unsigned IN_ROWS   = IMAGE_DIM / 2;
  localparam int unsigned IB_W      = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
  localparam int unsigned OB_W      = $clog2(OUT_BEATS);
  localparam int unsigned RW_W      = $clog2(IN_ROWS);

  localparam logic [IB_W-1:0] IB_LAST  = IB_W'(IN_BEATS - 1);
  localparam logic [OB_W-1:0] OB_LAST  = OB_W'(OUT_BEATS - 1);
  localparam logic [RW_W-1:0] ROW_LAST = RW_W'(IN_ROWS - 1);

  typedef enum logic {StIdle, StEmit} state_t;

  logic [DATA_WIDTH-1:0] r_mem [2][IN_BEATS];
  logic [1:0]            r_full;
  logic                  r_wr_bank;
  logic [IB_W-1:0]       r_wr_ptr;
  logic                  r_rd_bank;
  logic                  r_phase;
  logic [OB_W-1:0]       r_obeat;
  logic [RW_W-1:0]       r_row;
  state_t                r_state;

  logic                  w_wr_en;
  logic                  w_out_hs;
  logic                  w_last;
  logic                  w_bank_done;
  logic                  w_ld_en;
  logic                  w_ld_clr;
  logic                  w_ld_bank;
  logic                  w_ld_phase;
  logic [OB_W-1:0]       w_ld_obeat;
  logic                  w_ld_eol;
  logic                  w_ld_eof;
  logic [IB_W-1:0]       w_src_idx;
  logic                  w_half;
  logic [DATA_WIDTH-1:0] w_src;
  logic [HALF_DW-1:0]    w_half_px;
  logic [DATA_WIDTH-1:0] w_beat;
`ifdef PYR_EXPAND_SMOOTH_EN
  logic [IB_W-1:0]       w_nxt_idx;
  logic [DATA_WIDTH-1:0] w_nxt_src;
  logic [W-1:0]          w_edge_px;
`endif

  assign in_ready = ~r_full[r_wr_bank];
  assign w_wr_en  = in_valid & in_ready;
  assign w_out_hs = out_valid & out_ready;
  assign w_last   = r_phase & (r_obeat == OB_LAST);

  // Bank contents carry no reset; full flags gate every read.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_bank][r_wr_ptr] <= in_frame;
    end
  end

  // Choose the beat that enters the output register at the next edge.
  always_comb begin
    w_ld_en     = 1'b0;
    w_ld_clr    = 1'b0;
    w_bank_done = 1'b0;
    w_ld_bank   = r_rd_bank;
    w_ld_phase  = 1'b0;
    w_ld_obeat  = '0;
    unique case (r_state)
      StIdle: begin
        if (r_full[r_rd_bank]) begin
          w_ld_en = 1'b1;
        end
      end
      StEmit: begin
        if (w_out_hs) begin
          if (w_last) begin
            w_bank_done = 1'b1;
            if (r_full[~r_rd_bank]) begin
              w_ld_en   = 1'b1;
              w_ld_bank = ~r_rd_bank;
            end else begin
              w_ld_clr = 1'b1;
            end
          end else begin
            w_ld_en    = 1'b1;
            w_ld_phase = r_phase | (r_obeat == OB_LAST);
            w_ld_obeat = (r_obeat == OB_LAST) ? '0 : r_obeat + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign w_src_idx = IB_W'(w_ld_obeat >> 1);
  assign w_half    = w_ld_obeat[0];
  assign w_src     = r_mem[w_ld_bank][w_src_idx];
  assign w_half_px = w_half ? w_src[HALF_DW-1:0] : w_src[DATA_WIDTH-1:HALF_DW];
  // A new bank always starts at obeat 0, so a stale r_row never reaches a flagged beat.
  assign w_ld_eol  = (w_ld_obeat == OB_LAST);
  assign w_ld_eof  = w_ld_eol & w_ld_phase & (r_row == ROW_LAST);

`ifdef PYR_EXPAND_SMOOTH_EN
  assign w_nxt_idx = (w_src_idx == IB_LAST) ? w_src_idx : w_src_idx + 1'b1;
  assign w_nxt_src = r_mem[w_ld_bank][w_nxt_idx];

  // Right neighbour of the last pixel in this half-beat; the row's final pixel pairs with itself.
  always_comb begin
    w_edge_px = w_src[HALF_DW-1 -: W];
    if (w_half) begin
      w_edge_px = (w_src_idx == IB_LAST) ? w_half_px[W-1:0] : w_nxt_src[DATA_WIDTH-1 -: W];
    end
  end

  always_comb begin
    logic [W-1:0] px;
    logic [W-1:0] nx;
    logic [W:0]   sum;
    w_beat = '0;
    for (int k = 0; k < HALF; k++) begin
      px  = w_half_px[HALF_DW-1-k*W -: W];
      nx  = (k == HALF - 1) ? w_edge_px : w_half_px[HALF_DW-1-(k+1)*W -: W];
      sum = {1'b0, px} + {1'b0, nx} + (W+1)'(1);
      w_beat[DATA_WIDTH-1-(2*k)*W -: W]   = px;
      w_beat[DATA_WIDTH-1-(2*k+1)*W -: W] = sum[W:1];
    end
  end
`else
  always_comb begin
    logic [W-1:0] px;
    w_beat = '0;
    for (int k = 0; k < HALF; k++) begin
      px = w_half_px[HALF_DW-1-k*W -: W];
      w_beat[DATA_WIDTH-1-(2*k)*W -: W]   = px;
      w_beat[DATA_WIDTH-1-(2*k+1)*W -: W] = px;
    end
  end
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_bank <= 1'b0;
      r_phase   <= 1'b0;
      r_obeat   <= '0;
      r_row     <= '0;
      r_state   <= StIdle;
      out_valid <= 1'b0;
      out_frame <= '0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      if (w_wr_en) begin
        if (r_wr_ptr == IB_LAST) begin
          r_wr_ptr          <= '0;
          r_wr_bank         <= ~r_wr_bank;
          r_full[r_wr_bank] <= 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
      end

      // The write side only fills a bank that is not full, so set and clear never collide.
      if (w_bank_done) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
        r_row             <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end

      if (w_ld_en) begin
        out_valid <= 1'b1;
        out_frame <= w_beat;
        out_eol   <= w_ld_eol;
        out_eof   <= w_ld_eof;
        r_phase   <= w_ld_phase;
        r_obeat   <= w_ld_obeat;
        r_state   <= StEmit;
      end else if (w_ld_clr) begin
        out_valid <= 1'b0;
        out_eol   <= 1'b0;
        out_eof   <= 1'b0;
        r_phase   <= 1'b0;
        r_obeat   <= '0;
        r_state   <= StIdle;
      end
    end
  end

endmodule

// File: tb/tb_pyr_expand.sv
// Bench for pyr_expand: cycle table, backpressure, frame, async reset and random stress
// against a row-level upsampling model.
module tb_pyr_expand;

  localparam int P    = 4;
  localparam int W    = 8;
  localparam int DIM  = 16;
  localparam int DW   = P * W;
  localparam int IB   = DIM / (2 * P);
  localparam int OB   = 2 * IB;
  localparam int ROWS = DIM / 2;

  logic          clk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] in_frame;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_frame;
  logic          out_valid;
  logic          out_ready;
  logic          out_eol;
  logic          out_eof;

  always #5 clk = ~clk;

  pyr_expand #(
    .PIXELS_PER_BEAT(P),
    .INPUT_WIDTH    (W),
    .IMAGE_DIM      (DIM)
  ) u_dut (
    .clk      (clk),
    .aresetn  (aresetn),
    .in_frame (in_frame),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_frame(out_frame),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_eol  (out_eol),
    .out_eof  (out_eof)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: expands each completed input row into its expected output beats.
  typedef struct {
    logic [DW-1:0] d;
    logic          eol;
    logic          eof;
  } exp_t;

  exp_t         exq[$];
  logic [W-1:0] row_px[$];
  int           m_row;

  task automatic model_push(input logic [DW-1:0] fr);
    logic [W-1:0] up [2*P*IB];
    exp_t         e;
`ifdef PYR_EXPAND_SMOOTH_EN
    logic [W-1:0] nb;
`endif
    for (int p = 0; p < P; p++) row_px.push_back(fr[DW-1-p*W -: W]);
    if (row_px.size() == P * IB) begin
      for (int m = 0; m < P * IB; m++) begin
        up[2*m] = row_px[m];
`ifdef PYR_EXPAND_SMOOTH_EN
        nb = (m == P * IB - 1) ? row_px[m] : row_px[m+1];
        up[2*m+1] = W'((int'(row_px[m]) + int'(nb) + 1) / 2);
`else
        up[2*m+1] = row_px[m];
`endif
      end
      for (int ph = 0; ph < 2; ph++) begin
        for (int b = 0; b < OB; b++) begin
          e.d = '0;
          for (int j = 0; j < P; j++) e.d = (e.d << W) | DW'(up[b*P+j]);
          e.eol = (b == OB - 1);
          e.eof = e.eol && (ph == 1) && (m_row == ROWS - 1);
          exq.push_back(e);
        end
      end
      m_row = (m_row + 1) % ROWS;
      row_px.delete();
    end
  endtask

  logic          hold_chk;
  logic [DW+1:0] hold_val;
  logic          acc;
  int            hs_cnt;
  int            eof_cnt;
  int            eof_at;

  // One cycle: drive at the falling edge, then observe what the next rising edge will do.
  task automatic cyc(input logic iv, input logic [DW-1:0] fr, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    in_frame  = fr;
    out_ready = ordy;
    #1;
    if (hold_chk) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_beat", {out_frame, out_eol, out_eof}, hold_val);
    end
    hold_chk = out_valid && !out_ready;
    hold_val = {out_frame, out_eol, out_eof};
    acc = in_valid && in_ready;
    if (acc) model_push(in_frame);
    if (out_valid && out_ready) begin
      hs_cnt++;
      if (out_eof) begin
        eof_cnt++;
        eof_at = hs_cnt;
      end
      if (exq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL extra_beat: got %0h, expected no beat", out_frame);
      end else begin
        e = exq.pop_front();
        check("beat_data", out_frame, e.d);
        check("beat_eol", out_eol, e.eol);
        check("beat_eof", out_eof, e.eof);
      end
    end
  endtask

  task automatic feed(input int rows, input bit rnd);
    for (int i = 0; i < rows * IB; i++) begin
      logic [DW-1:0] d;
      int            t;
      d = $urandom;
      t = 0;
      do begin
        logic gap;
        gap = rnd && ($urandom_range(0, 2) == 0);
        cyc(!gap, d, rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        t++;
      end while (!acc && t < 200);
      if (!acc) begin
        n_vec++;
        n_bad++;
        $display("FAIL feed_timeout: got no accept in %0d cycles, expected accept", t);
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exq.size() != 0 && t < 500) begin
      cyc(1'b0, '0, 1'b1);
      t++;
    end
    check("drain_empty", exq.size(), 0);
  endtask

  task automatic clear_model();
    exq.delete();
    row_px.delete();
    m_row    = 0;
    hold_chk = 1'b0;
  endtask

  task automatic do_reset();
    aresetn   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] fr;
    logic          ordy;
    logic          e_ir;
    logic          e_ov;
    logic [DW-1:0] e_fr;
    logic          e_eol;
  } vec_t;

  vec_t tbl[12];

  task automatic run_table();
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].iv, tbl[i].fr, tbl[i].ordy);
      check($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ir);
      check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) begin
        check($sformatf("tbl%0d_out_frame", i), out_frame, tbl[i].e_fr);
        check($sformatf("tbl%0d_out_eol", i), out_eol, tbl[i].e_eol);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] bp_data [4];
    aresetn   = 1'b0;
    in_valid  = 1'b0;
    in_frame  = '0;
    out_ready = 1'b0;
    hs_cnt    = 0;
    eof_cnt   = 0;
    eof_at    = 0;
    acc       = 1'b0;
    hold_val  = '0;
    clear_model();

    //          iv    frame          ordy  ir    ov    frame          eol
    tbl[0]  = '{1'b1, 32'h01020304, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 32'h05060708, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h01010202, 1'b0};
    tbl[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h03030404, 1'b0};
    tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h05050606, 1'b0};
    tbl[6]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h07070808, 1'b1};
    tbl[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h01010202, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h03030404, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h05050606, 1'b0};
    tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h07070808, 1'b1};
    tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
`ifdef PYR_EXPAND_SMOOTH_EN
    tbl[3].e_fr  = 32'h01020203;
    tbl[4].e_fr  = 32'h03040405;
    tbl[5].e_fr  = 32'h05060607;
    tbl[6].e_fr  = 32'h07080808;
    tbl[7].e_fr  = 32'h01020203;
    tbl[8].e_fr  = 32'h03040405;
    tbl[9].e_fr  = 32'h05060607;
    tbl[10].e_fr = 32'h07080808;
`endif

    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_frame", out_frame, '0);
    check("rst_out_eol", out_eol, 1'b0);
    check("rst_out_eof", out_eof, 1'b0);

    run_table();

    // Backpressure: both banks fill while the output is stalled.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bp_data[i] = $urandom;
      cyc(1'b1, bp_data[i], 1'b0);
      check("bp_accept", acc, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'hdeadbeef, 1'b0);
      check("bp_in_ready", in_ready, 1'b0);
    end
    drain();
    cyc(1'b0, '0, 1'b1);
    check("bp_in_ready_after", in_ready, 1'b1);

    // Frame: eof only on beat 64 of the first frame, clear in the 9th row.
    do_reset();
    hs_cnt  = 0;
    eof_cnt = 0;
    eof_at  = 0;
    feed(9, 1'b0);
    drain();
    check("eof_count", eof_cnt, 1);
    check("eof_position", eof_at, 64);
    check("beat_total", hs_cnt, 72);

    // Asynchronous reset in the middle of phase 0.
    do_reset();
    cyc(1'b1, 32'h01020304, 1'b1);
    cyc(1'b1, 32'h05060708, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    check("pre_reset_valid", out_valid, 1'b1);
    #2;
    aresetn = 1'b0;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_in_ready", in_ready, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear_model();
    @(negedge clk);
    aresetn = 1'b1;
    run_table();

    // Random input gaps, random data and random output stalls.
    do_reset();
    feed(20, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
